cache_lru_tracker: RTL and testbench



---
 rtl/cache_lru_tracker.sv | 143 ++++++++++++++
 tb/tb_cache_lru_tracker.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_lru_tracker.sv
// Tree pseudo-LRU replacement tracker for a set-associative cache.
// Ports:
//   clk, reset                      clock, async active-high reset
//   fill_en, fill_set               victim request for a set
//   fill_way, fill_way_oh           victim, valid the cycle after fill_en
//   access_en, access_set           lookup; an update may follow
//   update_en, update_way_oh        mark the hit way MRU
module cache_lru_tracker #(
    parameter int NUM_WAYS = 4,
    parameter int NUM_SETS = 64,
    localparam int SW = $clog2(NUM_SETS),
    localparam int LW = $clog2(NUM_WAYS),
    localparam int WW = (LW < 1) ? 1 : LW,
    localparam int NB = (NUM_WAYS > 1) ? NUM_WAYS - 1 : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                fill_en,
    input  logic [SW-1:0]       fill_set,
    output logic [WW-1:0]       fill_way,
    output logic [NUM_WAYS-1:0] fill_way_oh,
    input  logic                access_en,
    input  logic [SW-1:0]       access_set,
    input  logic                update_en,
    input  logic [NUM_WAYS-1:0] update_way_oh
);

    logic [NB-1:0] tree_q [NUM_SETS];
    logic [SW-1:0] rd_set_q;
    logic [NB-1:0] rd_bits_q;
    logic          fill_pend_q;
    logic          acc_pend_q;

    logic [WW-1:0] victim;
    logic          wr_en;
    logic [NB-1:0] wr_bits;
    logic          rd_en;
    logic [SW-1:0] rd_set;
    logic [NB-1:0] rd_bits;

    // Walk from the root; each bit picks the child (0 = left).
    function automatic logic [WW-1:0] tree_victim(
        input logic [NB-1:0] bits
    );
        int node;
        int b;
        node = 0;
        for (int l = 0; l < LW; l++) begin
            b = 0;
            for (int n = 0; n < NB; n++) begin
                if (n == node) b = int'(bits[n]);
            end
            node = 2 * node + 1 + b;
        end
        return WW'(node - (NUM_WAYS - 1));
    endfunction

    // Point every node on way w's path away from w.
    function automatic logic [NB-1:0] tree_mru(
        input logic [NB-1:0] bits,
        input logic [WW-1:0] w
    );
        logic [NB-1:0] res;
        int node;
        int dir;
        res  = bits;
        node = 0;
        for (int l = 0; l < LW; l++) begin
            dir = (int'(w) >> (LW - 1 - l)) & 1;
            for (int n = 0; n < NB; n++) begin
                if (n == node) res[n] = (dir == 0);
            end
            node = 2 * node + 1 + dir;
        end
        return res;
    endfunction

    function automatic logic [WW-1:0] oh_to_idx(
        input logic [NUM_WAYS-1:0] oh
    );
        logic [WW-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (oh[i]) idx = idx | WW'(i);
        end
        return idx;
    endfunction

    function automatic logic [NUM_WAYS-1:0] idx_to_oh(
        input logic [WW-1:0] idx
    );
        return NUM_WAYS'(1) << idx;
    endfunction

    always_comb begin
        victim  = '0;
        wr_en   = 1'b0;
        wr_bits = rd_bits_q;
        rd_en   = fill_en | access_en;
        rd_set  = fill_en ? fill_set : access_set;
        if (NUM_WAYS > 1) begin
            victim = tree_victim(rd_bits_q);
            // The fill's own MRU update outranks any hit update.
            if (fill_pend_q) begin
                wr_en   = 1'b1;
                wr_bits = tree_mru(rd_bits_q, victim);
            end else if (acc_pend_q && update_en && |update_way_oh) begin
                wr_en   = 1'b1;
                wr_bits = tree_mru(rd_bits_q, oh_to_idx(update_way_oh));
            end
        end
        // Bypass so a same-set read sees the bits being written now.
        if (wr_en && rd_set == rd_set_q) begin
            rd_bits = wr_bits;
        end else begin
            rd_bits = tree_q[rd_set];
        end
    end

    assign fill_way    = victim;
    assign fill_way_oh = idx_to_oh(victim);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                tree_q[s] <= '0;
            end
            rd_set_q    <= '0;
            rd_bits_q   <= '0;
            fill_pend_q <= 1'b0;
            acc_pend_q  <= 1'b0;
        end else begin
            if (wr_en) tree_q[rd_set_q] <= wr_bits;
            fill_pend_q <= fill_en;
            acc_pend_q  <= access_en & ~fill_en;
            if (rd_en) begin
                rd_set_q  <= rd_set;
                rd_bits_q <= rd_bits;
            end
        end
    end

endmodule

// File: tb/tb_cache_lru_tracker.sv
// Self-checking bench for cache_lru_tracker (4 ways, 64 sets).
// Directed vector table plus random traffic against a recency model.
module tb_cache_lru_tracker;

    localparam int NW = 4;
    localparam int NS = 64;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          fill_en = 1'b0;
    logic [5:0]    fill_set = '0;
    logic [1:0]    fill_way;
    logic [NW-1:0] fill_way_oh;
    logic          access_en = 1'b0;
    logic [5:0]    access_set = '0;
    logic          update_en = 1'b0;
    logic [NW-1:0] update_way_oh = '0;

    cache_lru_tracker #(.NUM_WAYS(NW), .NUM_SETS(NS)) dut (
        .clk(clk),
        .reset(reset),
        .fill_en(fill_en),
        .fill_set(fill_set),
        .fill_way(fill_way),
        .fill_way_oh(fill_way_oh),
        .access_en(access_en),
        .access_set(access_set),
        .update_en(update_en),
        .update_way_oh(update_way_oh)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference: last-touch time per way. A tree node points away from
    // whichever half was touched most recently; untouched halves tie left.
    int unsigned ts [NS][NW];
    int unsigned now = 0;
    logic m_fill = 1'b0;
    logic m_acc = 1'b0;
    int   m_set = 0;
    int   m_vic = 0;

    function automatic int model_victim(int s);
        int lo, sz, half;
        int unsigned ml, mr;
        lo = 0;
        sz = NW;
        while (sz > 1) begin
            half = sz / 2;
            ml = 0;
            mr = 0;
            for (int i = 0; i < half; i++) begin
                if (ts[s][lo + i] > ml) ml = ts[s][lo + i];
                if (ts[s][lo + half + i] > mr) mr = ts[s][lo + half + i];
            end
            if (ml > mr) lo = lo + half;
            sz = half;
        end
        return lo;
    endfunction

    task automatic model_clear();
        for (int s = 0; s < NS; s++)
            for (int w = 0; w < NW; w++) ts[s][w] = 0;
        m_fill = 1'b0;
        m_acc = 1'b0;
    endtask

    task automatic touch(int s, int w);
        now++;
        ts[s][w] = now;
    endtask

    function automatic int oh_idx(logic [NW-1:0] oh);
        int r;
        r = 0;
        for (int i = 0; i < NW; i++) if (oh[i]) r = i;
        return r;
    endfunction

    // Applies the clock edge that just happened to the model, using the
    // inputs that were stable before it.
    task automatic model_edge();
        if (m_fill) touch(m_set, m_vic);
        else if (m_acc && update_en && update_way_oh != 0)
            touch(m_set, oh_idx(update_way_oh));
        m_fill = fill_en;
        m_acc = access_en && !fill_en;
        if (fill_en) begin
            m_set = int'(fill_set);
            m_vic = model_victim(m_set);
        end else if (access_en) begin
            m_set = int'(access_set);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_edge();
    endtask

    task automatic check(string name, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic drive(logic f, int fs, logic a, int as_,
                         logic u, logic [NW-1:0] oh);
        fill_en = f;
        fill_set = 6'(fs);
        access_en = a;
        access_set = 6'(as_);
        update_en = u;
        update_way_oh = oh;
    endtask

    typedef struct {
        logic          f;
        int            fs;
        logic          a;
        int            as_;
        logic          u;
        logic [NW-1:0] oh;
        logic          chk;
        int            exp;
        string         name;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic f, int fs, logic a, int as_, logic u,
                                logic [NW-1:0] oh, logic chk, int exp,
                                string name);
        vec_t v;
        v.f = f; v.fs = fs; v.a = a; v.as_ = as_; v.u = u; v.oh = oh;
        v.chk = chk; v.exp = exp; v.name = name;
        return v;
    endfunction

    initial begin
        int w;
        int k;
        logic [NW-1:0] exp_oh;

        vt.push_back(mk(1, 5, 0, 0, 0, 4'b0000, 1, 0, "set5_fill1"));
        vt.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 0, 0, "idle"));
        vt.push_back(mk(1, 5, 0, 0, 0, 4'b0000, 1, 2, "set5_fill2"));
        vt.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 0, 0, "idle"));
        vt.push_back(mk(1, 5, 0, 0, 0, 4'b0000, 1, 1, "set5_fill3"));
        vt.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 0, 0, "idle"));
        vt.push_back(mk(1, 5, 0, 0, 0, 4'b0000, 1, 3, "set5_fill4"));
        vt.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 0, 0, "idle"));
        vt.push_back(mk(0, 0, 1, 3, 0, 4'b0000, 0, 0, "acc3"));
        vt.push_back(mk(0, 0, 0, 0, 1, 4'b0001, 0, 0, "upd3"));
        vt.push_back(mk(1, 3, 0, 0, 0, 4'b0000, 1, 2, "set3_after_upd"));
        vt.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 0, 0, "idle"));
        vt.push_back(mk(0, 0, 1, 10, 0, 4'b0000, 0, 0, "acc10"));
        vt.push_back(mk(0, 0, 0, 0, 1, 4'b0000, 0, 0, "upd10_zero"));
        vt.push_back(mk(1, 10, 0, 0, 0, 4'b0000, 1, 0, "set10_zero_upd"));
        vt.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 0, 0, "idle"));
        vt.push_back(mk(1, 4, 1, 9, 0, 4'b0000, 1, 0, "fill4_acc9"));
        vt.push_back(mk(0, 0, 0, 0, 1, 4'b0001, 0, 0, "upd_dropped"));
        vt.push_back(mk(1, 9, 0, 0, 0, 4'b0000, 1, 0, "set9_unchanged"));
        vt.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 0, 0, "idle"));
        vt.push_back(mk(1, 7, 0, 0, 0, 4'b0000, 1, 0, "b2b_set7_a"));
        vt.push_back(mk(1, 7, 0, 0, 0, 4'b0000, 1, 2, "b2b_set7_b"));
        vt.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 0, 0, "idle"));
        vt.push_back(mk(0, 0, 1, 1, 0, 4'b0000, 0, 0, "acc1"));
        vt.push_back(mk(0, 0, 0, 0, 1, 4'b0001, 0, 0, "upd1"));
        vt.push_back(mk(1, 2, 0, 0, 0, 4'b0000, 1, 0, "set2_indep"));
        vt.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 0, 0, "idle"));

        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check("reset_way", int'(fill_way), 0);
        check("reset_oh", int'(fill_way_oh), 1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_reset_way", int'(fill_way), 0);
        check("post_reset_oh", int'(fill_way_oh), 1);

        foreach (vt[i]) begin
            drive(vt[i].f, vt[i].fs, vt[i].a, vt[i].as_, vt[i].u, vt[i].oh);
            tick();
            if (vt[i].chk) begin
                w = vt[i].exp;
                exp_oh = 4'(1 << w);
                check({vt[i].name, "_way"}, int'(fill_way), w);
                check({vt[i].name, "_oh"}, int'(fill_way_oh), int'(exp_oh));
                check({vt[i].name, "_model"}, m_vic, w);
            end
        end

        // Touch set 20, then reset mid-fill: everything must clear.
        drive(0, 0, 1, 20, 0, 4'b0000);
        tick();
        drive(1, 20, 0, 0, 1, 4'b0001);
        tick();
        drive(0, 0, 0, 0, 0, 4'b0000);
        #2;
        reset = 1'b1;
        #1;
        check("midreset_way", int'(fill_way), 0);
        check("midreset_oh", int'(fill_way_oh), 1);
        model_clear();
        @(negedge clk);
        reset = 1'b0;
        drive(1, 20, 0, 0, 0, 4'b0000);
        tick();
        check("after_midreset_way", int'(fill_way), 0);
        drive(0, 0, 0, 0, 0, 4'b0000);
        tick();

        for (int c = 0; c < 600; c++) begin
            k = int'($urandom_range(0, 4));
            drive(($urandom_range(0, 9) < 3),
                  int'($urandom_range(0, 7)),
                  ($urandom_range(0, 9) < 5),
                  int'($urandom_range(0, 7)),
                  ($urandom_range(0, 9) < 6),
                  (k == 4) ? 4'b0000 : 4'(1 << k));
            tick();
            if (m_fill) begin
                exp_oh = 4'(1 << m_vic);
                check("rand_way", int'(fill_way), m_vic);
                check("rand_oh", int'(fill_way_oh), int'(exp_oh));
            end
        end

        drive(0, 0, 0, 0, 0, 4'b0000);
        tick();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
